gate_tt_checker: RTL and testbench

GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

---
 rtl/gate_tt_checker.sv | 123 ++++++++++++
 tb/tb_gate_tt_checker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gate_tt_checker.sv
// Truth-table sweeper for mux-built logic gates: drives all four input vectors,
// compares each gate output against its ideal function and keeps sticky fault flags.
module gate_tt_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] gate_out,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask,
  output logic [3:0] fail_vec,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [3:0] SettleLoad = 4'(SETTLE);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] vec_q, vec_d;
  logic       pass_q, pass_d;
  logic [6:0] mask_q, mask_d;
  logic [3:0] fvec_q, fvec_d;

  logic       in1, in2;
  logic [6:0] expected;
  logic [6:0] mismatch;

  // Ideal gate responses for the vector being driven, in gate_out bit order.
  assign in1      = vec_q[1];
  assign in2      = vec_q[0];
  assign expected = {~(in1 ^ in2), in1 ^ in2, ~(in1 | in2), ~(in1 & in2),
                     ~in1, in1 | in2, in1 & in2};
  assign mismatch = expected ^ gate_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      vec_q   <= 2'd0;
      pass_q  <= 1'b0;
      mask_q  <= 7'd0;
      fvec_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      fvec_q  <= fvec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    pass_d  = pass_q;
    mask_d  = mask_q;
    fvec_d  = fvec_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pass_d  = 1'b0;
          mask_d  = 7'd0;
          fvec_d  = 4'd0;
          vec_d   = 2'd0;
          cnt_d   = SettleLoad;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CHECK: begin
        mask_d = mask_q | mismatch;
        if (|mismatch) begin
          fvec_d[vec_q] = 1'b1;
        end
        // Pass is judged on the mask including this final vector's mismatches.
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = SettleLoad;
          state_d = S_SETTLE;
        end else begin
          pass_d  = (mask_d == 7'd0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign drv_in1   = ((state_q == S_SETTLE) || (state_q == S_CHECK)) && vec_q[1];
  assign drv_in2   = ((state_q == S_SETTLE) || (state_q == S_CHECK)) && vec_q[0];
  assign pass      = pass_q;
  assign fail_mask = mask_q;
  assign fail_vec  = fvec_q;
  assign vec_idx   = vec_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Self-checking bench for gate_tt_checker: a behavioural gate model with injectable
// faults feeds two checkers (SETTLE=2 and SETTLE=1); expected sweep results go through a queue.
module tb_gate_tt_checker;

  typedef struct {
    int         cyc;
    logic       pass;
    logic [6:0] mask;
    logic [3:0] vec;
  } expT;

  logic       clk;
  logic       rstnA, rstnB, startA, startB;
  logic [6:0] gateA, gateB;
  logic       drvA1, drvA2, busyA, doneA, passA;
  logic       drvB1, drvB2, busyB, doneB, passB;
  logic [6:0] maskA, maskB;
  logic [3:0] fvecA, fvecB;
  logic [1:0] vidxA, vidxB;
  int         faultA, faultB;
  bit         selQ;

  int compared   = 0;
  int mismatched = 0;
  expT sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal gates, optionally with the xor stuck low (1) or the inverter built as a buffer (2).
  function automatic logic [6:0] gateModel(input logic a, input logic b, input int fault);
    logic [6:0] g;
    g = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    if (fault == 1) g[5] = 1'b0;
    if (fault == 2) g[2] = a;
    return g;
  endfunction

  assign gateA = gateModel(drvA1, drvA2, faultA);
  assign gateB = gateModel(drvB1, drvB2, faultB);

  gate_tt_checker #(.SETTLE(2)) dutA (
    .clk(clk), .rst_n(rstnA), .start(startA), .gate_out(gateA),
    .drv_in1(drvA1), .drv_in2(drvA2), .busy(busyA), .done(doneA), .pass(passA),
    .fail_mask(maskA), .fail_vec(fvecA), .vec_idx(vidxA)
  );

  gate_tt_checker #(.SETTLE(1)) dutB (
    .clk(clk), .rst_n(rstnB), .start(startB), .gate_out(gateB),
    .drv_in1(drvB1), .drv_in2(drvB2), .busy(busyB), .done(doneB), .pass(passB),
    .fail_mask(maskB), .fail_vec(fvecB), .vec_idx(vidxB)
  );

  logic       obsBusy, obsDone, obsPass, obsDrv1, obsDrv2;
  logic [6:0] obsMask;
  logic [3:0] obsVec;
  logic [1:0] obsIdx;
  assign obsBusy = selQ ? busyB : busyA;
  assign obsDone = selQ ? doneB : doneA;
  assign obsPass = selQ ? passB : passA;
  assign obsDrv1 = selQ ? drvB1 : drvA1;
  assign obsDrv2 = selQ ? drvB2 : drvA2;
  assign obsMask = selQ ? maskB : maskA;
  assign obsVec  = selQ ? fvecB : fvecA;
  assign obsIdx  = selQ ? vidxB : vidxA;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setStart(input logic v);
    if (selQ) startB = v; else startA = v;
  endtask

  task automatic setRst(input logic v);
    if (selQ) rstnB = v; else rstnA = v;
  endtask

  task automatic setFault(input int f);
    if (selQ) faultB = f; else faultA = f;
  endtask

  // Expected sweep outcome for a given fault, accepted at cycle startCyc.
  task automatic pushExp(input int startCyc, input int settle, input int fault);
    expT e;
    e.cyc = startCyc + 4 * (settle + 1) + 1;
    case (fault)
      1:       begin e.pass = 1'b0; e.mask = 7'b0100000; e.vec = 4'b0110; end
      2:       begin e.pass = 1'b0; e.mask = 7'b0000100; e.vec = 4'b1111; end
      default: begin e.pass = 1'b1; e.mask = 7'b0000000; e.vec = 4'b0000; end
    endcase
    sb.push_back(e);
  endtask

  // One scenario: start at cycle 0, optional extra start pulses, optional reset
  // cycle, optional restart in the cycle after the first done with fault2.
  task automatic applyStimulus(input bit sel, input int fault, input int fault2,
                               input int rp1, input int rp2, input int rstCyc,
                               input bit restart, input int nDone);
    int  settle;
    int  doneCount;
    bit  restartNow;
    bit  haveLast;
    expT e, lastExp;
    selQ       = sel;
    settle     = sel ? 1 : 2;
    doneCount  = 0;
    restartNow = 1'b0;
    haveLast   = 1'b0;
    lastExp    = '{0, 1'b0, 7'd0, 4'd0};
    setFault(fault);
    @(posedge clk); #1;
    setStart(1'b1);
    pushExp(0, settle, fault);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      setStart((k == rp1) || (k == rp2) || restartNow);
      if (restartNow) begin
        setFault(fault2);
        pushExp(k, settle, fault2);
        restartNow = 1'b0;
      end
      setRst(k != rstCyc);
      @(negedge clk);
      if (k == 1) begin
        checkOutput("busy in first settle", obsBusy, 1);
        checkOutput("drv vector 0", {obsDrv1, obsDrv2}, 2'b00);
      end
      if (k == settle + 2 && rstCyc < 0) begin
        checkOutput("vec_idx second vector", obsIdx, 1);
        checkOutput("drv vector 1", {obsDrv1, obsDrv2}, 2'b01);
      end
      if (k == rstCyc + 1) begin
        checkOutput("reset busy", obsBusy, 0);
        checkOutput("reset outputs",
                    {obsDone, obsPass, obsMask, obsVec, obsIdx, obsDrv1, obsDrv2}, 0);
      end
      if (obsDone) begin
        doneCount++;
        if (sb.size() == 0) begin
          checkOutput("unexpected done", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("done cycle", k, e.cyc);
          checkOutput("pass", obsPass, e.pass);
          checkOutput("fail_mask", obsMask, e.mask);
          checkOutput("fail_vec", obsVec, e.vec);
          checkOutput("drv idle in done", {obsDrv1, obsDrv2}, 2'b00);
          lastExp  = e;
          haveLast = 1'b1;
          if (restart && doneCount == 1) restartNow = 1'b1;
        end
      end
    end
    checkOutput("done count", doneCount, nDone);
    checkOutput("idle after sweep", obsBusy, 0);
    if (haveLast) begin
      checkOutput("held pass", obsPass, lastExp.pass);
      checkOutput("held fail_mask", obsMask, lastExp.mask);
      checkOutput("held fail_vec", obsVec, lastExp.vec);
    end
    sb.delete();
  endtask

  initial begin
    rstnA = 1'b0; rstnB = 1'b0; startA = 1'b0; startB = 1'b0;
    faultA = 0; faultB = 0; selQ = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset A", {busyA, doneA, passA, maskA, fvecA, vidxA, drvA1, drvA2}, 0);
    checkOutput("reset B", {busyB, doneB, passB, maskB, fvecB, vidxB, drvB1, drvB2}, 0);
    rstnA = 1'b1; rstnB = 1'b1;
    $display("[TB] clean sweep, SETTLE=2");
    applyStimulus(1'b0, 0, 0, -1, -1, -1, 1'b0, 1);
    $display("[TB] xor stuck low");
    applyStimulus(1'b0, 1, 0, -1, -1, -1, 1'b0, 1);
    $display("[TB] inverter built as buffer");
    applyStimulus(1'b0, 2, 0, -1, -1, -1, 1'b0, 1);
    $display("[TB] start re-pulsed mid-sweep");
    applyStimulus(1'b0, 0, 0, 3, 12, -1, 1'b0, 1);
    $display("[TB] reset mid-sweep");
    applyStimulus(1'b0, 0, 0, -1, -1, 6, 1'b0, 0);
    $display("[TB] SETTLE=1 faulty sweep then back-to-back clean sweep");
    applyStimulus(1'b1, 1, 0, -1, -1, -1, 1'b1, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
